// File: rtl/cla_multiword_sequencer_pkg.sv
// Shared definitions for the multi-word CLA sequencer: FSM state encoding and slice width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cla_multiword_sequencer_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_multiword_sequencer_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second-level group lookahead.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: a, b (16-bit addends), c_in (carry in) -> s (16-bit sum), c_out (carry out).
module cla_multiword_sequencer_cla16
    import cla_multiword_sequencer_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c_in,
    output logic [SLICE_W-1:0] s,
    output logic               c_out
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        gg = '0;
        gp = '0;
        gc = '0;

        // Group generate/propagate for each 4-bit nibble.
        for (int j = 0; j < 4; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end

        // Second-level lookahead: group carries depend only on c_in, gg and gp.
        gc[0] = c_in;
        gc[1] = gg[0] | (gp[0] & c_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & c_in);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

        // Within a nibble the carry ripples from the group carry-in.
        for (int j = 0; j < 4; j++) begin
            c[4*j] = gc[j];
            for (int k = 1; k < 4; k++) begin
                c[4*j+k] = g[4*j+k-1] | (p[4*j+k-1] & c[4*j+k-1]);
            end
        end

        s     = p ^ c;
        c_out = gc[4];
    end

endmodule

// File: rtl/cla_multiword_sequencer.sv
// Adds/subtracts (16*WORDS)-bit operands by running one 16-bit CLA over the slices, LSB first.
// Latency: accept in cycle 0, out_valid in cycle WORDS+1; issue interval WORDS+2.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
// Ports: clk, rst (async, active-high); in_valid/in_ready with sub, a, b sampled at accept;
//        out_valid/out_ready with sum, c_out (carry/no-borrow) and ovf (signed overflow).
module cla_multiword_sequencer
    import cla_multiword_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sub,
    input  logic [SLICE_W*WORDS-1:0] a,
    input  logic [SLICE_W*WORDS-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*WORDS-1:0] sum,
    output logic                     c_out,
    output logic                     ovf
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;

    // Current slice of each operand register, selected by idx.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                slice_a = a_q[k*SLICE_W +: SLICE_W];
                slice_b = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    cla_multiword_sequencer_cla16 u_cla16 (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1: invert B once and seed the carry.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int k = 0; k < WORDS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k*SLICE_W +: SLICE_W] = slice_s;
                    end
                end
                carry_d = slice_co;
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    c_out_d = slice_co;
                    // Overflow: same-sign operands (after B inversion) giving a different-sign result.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_s[SLICE_W-1] != a_q[W-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Self-checking bench for cla_multiword_sequencer (WORDS=4 main instance, WORDS=1 side instance).
// Latency: checks out_valid timing of WORDS+1 cycles after the accept cycle.
// Backpressure: exercises held requests and stalled results via out_ready.
module tb_cla_multiword_sequencer;

    localparam int WORDS = 4;
    localparam int LAT   = WORDS + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready, c_out, ovf;
    logic [63:0] a, b, sum;
    logic        in1_valid, in1_ready, sub1, out1_valid, out1_ready, c1_out, ovf1;
    logic [15:0] a1, b1, sum1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: one operation outstanding at most.
    bit          busy = 1'b0;
    int          age  = 0;
    logic [63:0] e_sum;
    logic        e_c, e_v;
    bit          rand_rdy = 1'b0;

    always #5 clk = ~clk;

    cla_multiword_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    cla_multiword_sequencer #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready), .sub(sub1),
        .a(a1), .b(b1), .out_valid(out1_valid), .out_ready(out1_ready),
        .sum(sum1), .c_out(c1_out), .ovf(ovf1)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Arithmetic reference for an n-bit add/sub, from integer semantics.
    function automatic void model(input logic [63:0] ai, input logic [63:0] bi, input bit si,
                                  input int n, output logic [63:0] s_o,
                                  output logic c_o, output logic v_o);
        logic [64:0]        mask, ua, ub, r;
        logic signed [66:0] lim, sa, sb, sr;
        mask = (65'd1 << n) - 65'd1;
        ua   = {1'b0, ai} & mask;
        ub   = {1'b0, bi} & mask;
        if (si) begin
            r   = ua - ub;
            c_o = (ua >= ub);
        end else begin
            r   = ua + ub;
            c_o = r[n];
        end
        s_o = r[63:0] & mask[63:0];
        lim = 67'sd1 <<< (n - 1);
        sa  = ua[n-1] ? $signed({2'b00, ua}) - 2 * lim : $signed({2'b00, ua});
        sb  = ub[n-1] ? $signed({2'b00, ub}) - 2 * lim : $signed({2'b00, ub});
        sr  = si ? sa - sb : sa + sb;
        v_o = (sr >= lim) || (sr < -lim);
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            1:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'h0;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Per-cycle compare against the reference for the WORDS=4 instance.
    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0;
            age  = 0;
        end else begin
            if (busy) age++;
            chk("in_ready", in_ready, !busy);
            chk("out_valid", out_valid, busy && (age >= LAT));
            if (busy && (age >= LAT)) begin
                chk("sum", sum, e_sum);
                chk("c_out", c_out, e_c);
                chk("ovf", ovf, e_v);
            end
            if (busy && (age >= LAT) && out_ready) begin
                busy = 1'b0;
            end else if (!busy && in_valid) begin
                model(a, b, sub, 64, e_sum, e_c, e_v);
                busy = 1'b1;
                age  = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic drive(input logic [63:0] ai, input logic [63:0] bi, input bit si);
        bit acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = ai;
        b        = bi;
        sub      = si;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) timeout("accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        sub      = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_out(output int lat, output logic [63:0] s,
                            output logic c, output logic v);
        lat = 0;
        s   = '0;
        c   = 1'b0;
        v   = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                s   = sum;
                c   = c_out;
                v   = ovf;
                break;
            end
        end
        if (lat == 0) timeout("out_valid");
    endtask

    task automatic run1(input logic [15:0] ai, input logic [15:0] bi, input bit si,
                        output int lat, output logic [15:0] s, output logic c, output logic v);
        bit acc;
        acc = 1'b0;
        lat = 0;
        s   = '0;
        c   = 1'b0;
        v   = 1'b0;
        @(posedge clk);
        #1;
        in1_valid = 1'b1;
        a1        = ai;
        b1        = bi;
        sub1      = si;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in1_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) timeout("accept1");
        @(posedge clk);
        #1;
        in1_valid = 1'b0;
        a1        = 16'($urandom);
        b1        = 16'($urandom);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out1_valid) begin
                lat = i;
                s   = sum1;
                c   = c1_out;
                v   = ovf1;
                break;
            end
        end
        if (lat == 0) timeout("out1_valid");
    endtask

    initial begin
        int          lat;
        logic [63:0] s;
        logic        c, v;
        logic [15:0] s1, m16;
        logic [63:0] ms, ra, rb;
        logic        mc, mv;
        bit          rs;
        bit          drained;

        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        sub        = 1'b0;
        out_ready  = 1'b1;
        in1_valid  = 1'b0;
        a1         = '0;
        b1         = '0;
        sub1       = 1'b0;
        out1_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 64'h0);
        chk("rst_c_out", c_out, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in1_ready", in1_ready, 1'b1);
        chk("rst_out1_valid", out1_valid, 1'b0);
        #2 rst = 1'b0;

        // All-ones plus one wraps to zero with carry.
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_out(lat, s, c, v);
        chk("t1_latency", 64'(lat), 64'(LAT));
        chk("t1_sum", s, 64'h0);
        chk("t1_c_out", c, 1'b1);
        chk("t1_ovf", v, 1'b0);

        // Max positive plus one overflows.
        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_out(lat, s, c, v);
        chk("t2_sum", s, 64'h8000_0000_0000_0000);
        chk("t2_c_out", c, 1'b0);
        chk("t2_ovf", v, 1'b1);

        drive(64'd5, 64'd6, 1'b1);
        wait_out(lat, s, c, v);
        chk("t3a_sum", s, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3a_c_out", c, 1'b0);
        chk("t3a_ovf", v, 1'b0);

        drive(64'd500, 64'd500, 1'b0);
        wait_out(lat, s, c, v);
        chk("t3b_sum", s, 64'd1000);
        chk("t3b_c_out", c, 1'b0);
        chk("t3b_ovf", v, 1'b0);

        // Stalled result with a held request behind it.
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
        wait_out(lat, s, c, v);
        chk("t4_sum", s, 64'h1234_5678_9ABC_DF00);
        chk("t4_c_out", c, 1'b0);
        chk("t4_ovf", v, 1'b0);
        fork
            drive(64'd100, 64'd58, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t4_bp_in_ready", in_ready, 1'b0);
                    chk("t4_bp_out_valid", out_valid, 1'b1);
                    chk("t4_bp_sum", sum, s);
                    chk("t4_bp_c_out", c_out, c);
                    chk("t4_bp_ovf", ovf, v);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_out(lat, s, c, v);
        chk("t4_held_latency", 64'(lat), 64'(LAT));
        chk("t4_held_sum", s, 64'd42);
        chk("t4_held_c_out", c, 1'b1);
        chk("t4_held_ovf", v, 1'b0);

        // Abort in the third RUN cycle (idx=2).
        drive(64'hDEAD_BEEF_0000_1234, 64'h1, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_in_ready", in_ready, 1'b1);
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_sum", sum, 64'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        drive(64'd6, 64'd5, 1'b0);
        wait_out(lat, s, c, v);
        chk("t5_sum_after", s, 64'd11);

        // Single-slice instance.
        run1(16'hFFFF, 16'hFFFF, 1'b0, lat, s1, c, v);
        chk("t6_latency", 64'(lat), 64'd2);
        chk("t6_sum", 64'(s1), 64'hFFFE);
        chk("t6_c_out", c, 1'b1);
        chk("t6_ovf", v, 1'b0);
        run1(16'h7FFF, 16'h0001, 1'b0, lat, s1, c, v);
        chk("t6b_sum", 64'(s1), 64'h8000);
        chk("t6b_ovf", v, 1'b1);
        run1(16'h8000, 16'h0001, 1'b1, lat, s1, c, v);
        chk("t6c_sum", 64'(s1), 64'h7FFF);
        chk("t6c_c_out", c, 1'b1);
        chk("t6c_ovf", v, 1'b1);
        for (int i = 0; i < 30; i++) begin
            ra  = 64'(16'($urandom));
            rb  = 64'(16'($urandom));
            rs  = 1'($urandom_range(0, 1));
            run1(ra[15:0], rb[15:0], rs, lat, s1, c, v);
            model(ra, rb, rs, 16, ms, mc, mv);
            m16 = ms[15:0];
            chk("w1_rand_sum", 64'(s1), 64'(m16));
            chk("w1_rand_c_out", c, mc);
            chk("w1_rand_ovf", v, mv);
        end

        // Randomized traffic with random consumer backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            drive(rnd64(), rnd64(), 1'($urandom_range(0, 1)));
        end
        drained = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) timeout("drain");
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
